// File: rtl/axis_ins_hdr_pkg.sv
// Shared types and helpers for the AXI-Stream header inserter.
// Lane numbering is MSB-first: keep bit N-1 is lane 0 (data[DATA_WD-1 -: 8]).
package axis_ins_hdr_pkg;

  typedef enum logic [1:0] {
    S_HDR,
    S_BODY,
    S_TAIL
  } state_e;

  // Widest keep vector the helpers handle (DATA_WD up to 512).
  localparam int unsigned KeepMax = 64;

  typedef logic [KeepMax-1:0] keep_max_t;
  typedef logic [6:0]         cnt_t;

  // Number of set bits in a keep vector.
  function automatic cnt_t keep_count(input keep_max_t keep);
    cnt_t c;
    c = '0;
    for (int i = 0; i < KeepMax; i++) begin
      c = c + cnt_t'(keep[i]);
    end
    return c;
  endfunction

  // Keep vector with the top 'cnt' of 'lanes' lanes set (MSB-aligned).
  function automatic keep_max_t msb_mask(input cnt_t cnt, input cnt_t lanes);
    keep_max_t m;
    m = '0;
    for (int i = 0; i < KeepMax; i++) begin
      if ((cnt_t'(i) < lanes) && (cnt_t'(i) >= lanes - cnt)) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_ins_hdr_merge.sv
// Combinational byte merge: the H carried bytes go to the top lanes, followed by
// the top N-H bytes of the incoming beat; the low H bytes of the beat become the
// next carry.
module axis_ins_hdr_merge #(
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned CNT_WD  = $clog2(DATA_WD / 8 + 1)
) (
  input  logic [DATA_WD-1:0] i_carry,
  input  logic [DATA_WD-1:0] i_data,
  input  logic [CNT_WD-1:0]  i_hlen,
  output logic [DATA_WD-1:0] o_beat,
  output logic [DATA_WD-1:0] o_carry,
  output logic [DATA_WD-1:0] o_tail
);

  localparam int unsigned N = DATA_WD / 8;
  localparam logic [CNT_WD-1:0] NLanes = CNT_WD'(N);

  logic [CNT_WD-1:0]  w_hi_len;
  logic [DATA_WD-1:0] w_ones;

  assign w_hi_len = NLanes - i_hlen;
  assign w_ones   = '1;

  // Carry holds its bytes right-aligned; shifting left by N-H lanes MSB-aligns them.
  // With H=N the data shift reaches the full width and contributes nothing.
  assign o_tail  = i_carry << {w_hi_len, 3'b000};
  assign o_beat  = o_tail | (i_data >> {i_hlen, 3'b000});
  assign o_carry = i_data & ~(w_ones << {i_hlen, 3'b000});

endmodule

// File: rtl/axis_insert_header_pipe.sv
// Inserts a 1..N byte header in front of each AXI-Stream packet, re-packing the
// payload so that output beats stay dense. One registered output stage.
// Optional keep protocol checker (err_keep output) enabled by AXIS_INSERT_HEADER_CHK_EN.
module axis_insert_header_pipe
  import axis_ins_hdr_pkg::*;
#(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  output logic                    ready_insert
`ifdef AXIS_INSERT_HEADER_CHK_EN
  ,
  output logic                    err_keep
`endif
);

  localparam int unsigned N    = DATA_BYTE_WD;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [CntW:0] NSum = (CntW + 1)'(N);

  state_e              r_state;
  logic [CntW-1:0]     r_hlen;
  logic [CntW-1:0]     r_tail_len;
  logic [DATA_WD-1:0]  r_carry;
  logic                r_valid_out;
  logic [DATA_WD-1:0]  r_data_out;
  logic [N-1:0]        r_keep_out;
  logic                r_last_out;

  logic                w_out_free;
  logic                w_hs_hdr;
  logic                w_hs_in;
  logic [CntW-1:0]     w_h_in;
  logic [CntW-1:0]     w_l_in;
  logic [CntW:0]       w_sum;
  logic [CntW:0]       w_mask_cnt;
  logic                w_fits;
  logic [N-1:0]        w_keep_mask;
  logic [DATA_WD-1:0]  w_byte_mask;
  logic [DATA_WD-1:0]  w_hdr_mask;
  logic [DATA_WD-1:0]  w_ones;
  logic [DATA_WD-1:0]  w_beat;
  logic [DATA_WD-1:0]  w_carry_next;
  logic [DATA_WD-1:0]  w_tail;

  // Handshakes; both readies are forced low while reset is asserted.
  assign w_out_free   = !r_valid_out || ready_out;
  assign ready_insert = !rst && (r_state == S_HDR);
  assign ready_in     = !rst && (r_state == S_BODY) && w_out_free;
  assign w_hs_hdr     = valid_insert && ready_insert;
  assign w_hs_in      = valid_in && ready_in;

  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign keep_out  = r_keep_out;
  assign last_out  = r_last_out;

  axis_ins_hdr_merge #(
    .DATA_WD (DATA_WD),
    .CNT_WD  (CntW)
  ) u_merge (
    .i_carry (r_carry),
    .i_data  (data_in),
    .i_hlen  (r_hlen),
    .o_beat  (w_beat),
    .o_carry (w_carry_next),
    .o_tail  (w_tail)
  );

  // Byte counts, final-beat keep mask and its byte-wide data mask.
  always_comb begin
    w_h_in      = CntW'(keep_count(keep_max_t'(keep_insert)));
    w_l_in      = CntW'(keep_count(keep_max_t'(keep_in)));
    w_sum       = {1'b0, r_hlen} + {1'b0, w_l_in};
    w_fits      = (w_sum <= NSum);
    // In S_TAIL the mask covers the residual bytes, otherwise the whole H+L packet end.
    w_mask_cnt  = (r_state == S_TAIL) ? {1'b0, r_tail_len} : w_sum;
    w_keep_mask = N'(msb_mask(cnt_t'(w_mask_cnt), cnt_t'(N)));
    w_byte_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_byte_mask[i*8 +: 8] = {8{w_keep_mask[i]}};
    end
    w_ones     = '1;
    w_hdr_mask = ~(w_ones << {w_h_in, 3'b000});
  end

  // Packet FSM with the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HDR;
      r_hlen      <= '0;
      r_tail_len  <= '0;
      r_carry     <= '0;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_keep_out  <= '0;
      r_last_out  <= 1'b0;
    end else begin
      if (ready_out) begin
        r_valid_out <= 1'b0;
      end
      case (r_state)
        S_HDR: begin
          if (w_hs_hdr) begin
            r_hlen  <= w_h_in;
            r_carry <= data_insert & w_hdr_mask;
            r_state <= S_BODY;
          end
        end
        S_BODY: begin
          if (w_hs_in) begin
            r_valid_out <= 1'b1;
            r_carry     <= w_carry_next;
            if (last_in && w_fits) begin
              r_data_out <= w_beat & w_byte_mask;
              r_keep_out <= w_keep_mask;
              r_last_out <= 1'b1;
              r_state    <= S_HDR;
            end else begin
              r_data_out <= w_beat;
              r_keep_out <= '1;
              r_last_out <= 1'b0;
              if (last_in) begin
                r_tail_len <= CntW'(w_sum - NSum);
                r_state    <= S_TAIL;
              end
            end
          end
        end
        S_TAIL: begin
          if (w_out_free) begin
            r_valid_out <= 1'b1;
            r_data_out  <= w_tail & w_byte_mask;
            r_keep_out  <= w_keep_mask;
            r_last_out  <= 1'b1;
            r_state     <= S_HDR;
          end
        end
        default: r_state <= S_HDR;
      endcase
    end
  end

`ifdef AXIS_INSERT_HEADER_CHK_EN
  logic r_err_keep;
  logic w_hdr_keep_ok;
  logic w_last_keep_ok;
  cnt_t w_h_cnt;
  cnt_t w_l_cnt;

  // Header keep must be right-aligned contiguous, last payload keep MSB-aligned.
  assign w_h_cnt        = keep_count(keep_max_t'(keep_insert));
  assign w_l_cnt        = keep_count(keep_max_t'(keep_in));
  assign w_hdr_keep_ok  = (w_h_cnt != '0) &&
                          (keep_max_t'(keep_insert) == msb_mask(w_h_cnt, w_h_cnt));
  assign w_last_keep_ok = (w_l_cnt != '0) &&
                          (keep_max_t'(keep_in) == msb_mask(w_l_cnt, cnt_t'(N)));

  // Sticky keep protocol error flag, observed on accepted beats only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_keep <= 1'b0;
    end else if ((w_hs_hdr && !w_hdr_keep_ok) ||
                 (w_hs_in && !last_in && !(&keep_in)) ||
                 (w_hs_in && last_in && !w_last_keep_ok)) begin
      r_err_keep <= 1'b1;
    end
  end

  assign err_keep = r_err_keep;
`endif

endmodule

// File: tb/tb_axis_insert_header_pipe.sv
// Self-checking bench for axis_insert_header_pipe (DATA_WD=32). Expected beats are
// produced by a byte-stream model and queued when each packet is driven.
module tb_axis_insert_header_pipe;

  localparam int DW = 32;
  localparam int N  = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [N-1:0]  keep;
    logic          last;
  } beat_t;

  typedef logic [DW-1:0] word_q_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic [N-1:0]  keep_in;
  logic          last_in;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [N-1:0]  keep_out;
  logic          last_out;
  logic          ready_out;
  logic          valid_insert;
  logic [DW-1:0] data_insert;
  logic [N-1:0]  keep_insert;
  logic          ready_insert;

  beat_t exp_q[$];
  beat_t last_seen;
  beat_t hold_b;
  beat_t got;
  beat_t exp_b;
  bit    hold_valid = 1'b0;
  bit    rand_ready = 1'b0;
  bit    rand_gap   = 1'b0;
  int    checks  = 0;
  int    errors  = 0;
  int    out_cnt = 0;
  int    cyc     = 0;

  axis_insert_header_pipe #(
    .DATA_WD      (DW),
    .DATA_BYTE_WD (N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .keep_in      (keep_in),
    .last_in      (last_in),
    .ready_in     (ready_in),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .keep_out     (keep_out),
    .last_out     (last_out),
    .ready_out    (ready_out),
    .valid_insert (valid_insert),
    .data_insert  (data_insert),
    .keep_insert  (keep_insert),
    .ready_insert (ready_insert)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Output sink: random or constant backpressure.
  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_out = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_valid = 1'b0;
    end else begin
      got = {data_out, keep_out, last_out};
      if (hold_valid) begin
        checks++;
        if (!valid_out || got !== hold_b) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %h/%b/%0b required v=1 %h/%b/%0b",
                   valid_out, got.data, got.keep, got.last, hold_b.data, hold_b.keep,
                   hold_b.last);
        end
      end
      if (valid_out && ready_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h/%b/%0b required no beat",
                   got.data, got.keep, got.last);
        end else begin
          exp_b = exp_q.pop_front();
          if (got !== exp_b) begin
            errors++;
            $display("FAIL out_beat: got %h/%b/%0b required %h/%b/%0b",
                     got.data, got.keep, got.last, exp_b.data, exp_b.keep, exp_b.last);
          end
        end
        out_cnt++;
        last_seen = got;
      end
      hold_valid = valid_out && !ready_out;
      hold_b     = got;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end

  function automatic int popc(input logic [N-1:0] k);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(k[i]);
    return c;
  endfunction

  // Reference: header bytes then payload bytes as one byte stream, re-chopped to N lanes.
  task automatic model_push(input logic [DW-1:0] hdr, input logic [N-1:0] hkeep,
                            input word_q_t pl, input logic [N-1:0] lkeep);
    byte unsigned bq[$];
    beat_t b;
    int h = popc(hkeep);
    int l;
    for (int i = 0; i < h; i++) bq.push_back(hdr[(h-1-i)*8 +: 8]);
    for (int j = 0; j < pl.size(); j++) begin
      l = (j == pl.size() - 1) ? popc(lkeep) : N;
      for (int k = 0; k < l; k++) bq.push_back(pl[j][DW-1-k*8 -: 8]);
    end
    while (bq.size() > 0) begin
      b = '0;
      for (int k = 0; k < N; k++) begin
        if (bq.size() > 0) begin
          b.data[DW-1-k*8 -: 8] = bq.pop_front();
          b.keep[N-1-k] = 1'b1;
        end
      end
      b.last = (bq.size() == 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic put_header(input logic [DW-1:0] hdr, input logic [N-1:0] hkeep);
    bit hs = 1'b0;
    int budget = 0;
    valid_insert = 1'b1;
    data_insert  = hdr;
    keep_insert  = hkeep;
    while (!hs) begin
      @(negedge clk);
      hs = valid_insert && ready_insert;
      @(posedge clk);
      #1;
      budget++;
      if (!hs && budget > 1000) begin
        checks++;
        errors++;
        $display("FAIL header_handshake: got no ready_insert required handshake");
        break;
      end
    end
    valid_insert = 1'b0;
  endtask

  task automatic put_beat(input logic [DW-1:0] d, input logic [N-1:0] k, input logic l);
    bit hs = 1'b0;
    int budget = 0;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    while (!hs) begin
      @(negedge clk);
      hs = valid_in && ready_in;
      @(posedge clk);
      #1;
      budget++;
      if (!hs && budget > 1000) begin
        checks++;
        errors++;
        $display("FAIL payload_handshake: got no ready_in required handshake");
        break;
      end
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic send_packet(input logic [DW-1:0] hdr, input logic [N-1:0] hkeep,
                             input word_q_t pl, input logic [N-1:0] lkeep);
    model_push(hdr, hkeep, pl, lkeep);
    put_header(hdr, hkeep);
    for (int j = 0; j < pl.size(); j++) begin
      if (rand_gap && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      put_beat(pl[j], (j == pl.size() - 1) ? lkeep : {N{1'b1}}, j == pl.size() - 1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; keep_insert = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({valid_out, data_out, keep_out, last_out, ready_in, ready_insert} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b %h/%b/%0b rdy_in=%0b rdy_ins=%0b required all 0",
               valid_out, data_out, keep_out, last_out, ready_in, ready_insert);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_insert !== 1'b1 || ready_in !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy_ins=%0b rdy_in=%0b required 1/0",
               ready_insert, ready_in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_two_byte_header();
    word_q_t pl;
    int c0 = out_cnt;
    pl = '{32'h11223344, 32'h55667788};
    send_packet(32'h0000AABB, 4'b0011, pl, 4'b1111);
    drain();
    checks++;
    if (out_cnt - c0 != 3) begin
      errors++;
      $display("FAIL beats_two_byte_hdr: got %0d required 3", out_cnt - c0);
    end
    checks++;
    if (last_seen !== {32'h77880000, 4'b1100, 1'b1}) begin
      errors++;
      $display("FAIL tail_two_byte_hdr: got %h/%b/%0b required 77880000/1100/1",
               last_seen.data, last_seen.keep, last_seen.last);
    end
  endtask

  task automatic test_single_beat();
    word_q_t pl;
    int c0 = out_cnt;
    pl = '{32'hDD000000};
    send_packet(32'h000000CC, 4'b0001, pl, 4'b1000);
    drain();
    checks++;
    if (out_cnt - c0 != 1 || last_seen !== {32'hCCDD0000, 4'b1100, 1'b1}) begin
      errors++;
      $display("FAIL single_beat: got n=%0d %h/%b/%0b required n=1 ccdd0000/1100/1",
               out_cnt - c0, last_seen.data, last_seen.keep, last_seen.last);
    end
  endtask

  task automatic test_full_header();
    word_q_t pl;
    int c0 = out_cnt;
    pl = '{32'h01020304};
    send_packet(32'hA1A2A3A4, 4'b1111, pl, 4'b1110);
    drain();
    checks++;
    if (out_cnt - c0 != 2 || last_seen !== {32'h01020300, 4'b1110, 1'b1}) begin
      errors++;
      $display("FAIL full_header: got n=%0d %h/%b/%0b required n=2 01020300/1110/1",
               out_cnt - c0, last_seen.data, last_seen.keep, last_seen.last);
    end
  endtask

  task automatic test_back_to_back();
    word_q_t pl;
    int c0 = out_cnt;
    int t0;
    rand_ready = 1'b0;
    rand_gap   = 1'b0;
    @(posedge clk);
    #1;
    t0 = cyc;
    for (int p = 0; p < 4; p++) begin
      pl = {};
      for (int j = 0; j < 8; j++) pl.push_back($urandom);
      send_packet($urandom, 4'b0011, pl, 4'b1100);
    end
    checks++;
    if (cyc - t0 != 36) begin
      errors++;
      $display("FAIL b2b_cycles: got %0d required 36", cyc - t0);
    end
    drain();
    checks++;
    if (out_cnt - c0 != 32) begin
      errors++;
      $display("FAIL b2b_beats: got %0d required 32", out_cnt - c0);
    end
  endtask

  task automatic test_random();
    word_q_t pl;
    int c0 = out_cnt;
    int exp_n = 0;
    int nb, h, l;
    logic [N-1:0] hk, lk;
    rand_ready = 1'b1;
    rand_gap   = 1'b1;
    for (int p = 0; p < 4; p++) begin
      nb = (p == 0) ? 100 : int'($urandom_range(1, 6));
      h  = int'($urandom_range(1, N));
      l  = int'($urandom_range(1, N));
      hk = '1;
      hk = ~(hk << h);
      lk = '1;
      lk = lk << (N - l);
      pl = {};
      for (int j = 0; j < nb; j++) pl.push_back($urandom);
      exp_n += (h + (nb - 1) * N + l + N - 1) / N;
      send_packet($urandom, hk, pl, lk);
    end
    rand_gap = 1'b0;
    drain();
    rand_ready = 1'b0;
    checks++;
    if (out_cnt - c0 != exp_n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_beats: got %0d left=%0d required %0d left=0",
               out_cnt - c0, exp_q.size(), exp_n);
    end
  endtask

  task automatic test_reset_mid_packet();
    int c0;
    exp_q.push_back({32'hEEFF0102, 4'b1111, 1'b0});
    exp_q.push_back({32'h03040506, 4'b1111, 1'b0});
    put_header(32'h0000EEFF, 4'b0011);
    put_beat(32'h01020304, 4'b1111, 1'b0);
    put_beat(32'h05060708, 4'b1111, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({valid_out, data_out, keep_out, last_out, ready_in, ready_insert} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got v=%0b %h/%b/%0b rdy_in=%0b rdy_ins=%0b required 0",
               valid_out, data_out, keep_out, last_out, ready_in, ready_insert);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_insert !== 1'b1 || ready_in !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release: got rdy_ins=%0b rdy_in=%0b required 1/0",
               ready_insert, ready_in);
    end
    @(posedge clk);
    #1;
    c0 = out_cnt;
    begin
      word_q_t pl;
      pl = '{32'hAABBCCDD};
      send_packet(32'h123456C1, 4'b0001, pl, 4'b1111);
    end
    drain();
    checks++;
    if (out_cnt - c0 != 2 || last_seen !== {32'hDD000000, 4'b1000, 1'b1}) begin
      errors++;
      $display("FAIL after_reset_pkt: got n=%0d %h/%b/%0b required n=2 dd000000/1000/1",
               out_cnt - c0, last_seen.data, last_seen.keep, last_seen.last);
    end
  endtask

  initial begin
    test_reset();
    test_two_byte_header();
    test_single_beat();
    test_full_header();
    test_back_to_back();
    test_random();
    test_reset_mid_packet();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
